muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits; legal values are 8 to 64.
REQ-002 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 clear  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; it is sampled only in IDLE.
REQ-005 op  input  1  SHALL select the operation: 0 = MUL, 1 = DIV.
REQ-006 a  input  WIDTH  SHALL be the multiplicand or dividend, two's complement.
REQ-007 b  input  WIDTH  SHALL be the multiplier or divisor, two's complement.
REQ-008 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 hi  output  WIDTH  SHALL carry the product upper half or the remainder.
REQ-011 lo  output  WIDTH  SHALL carry the product lower half or the quotient.
REQ-012 dz  output  1  SHALL be the divide-by-zero flag for the last completed operation.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, FIX and DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL latch a, b and op, load the step counter with WIDTH, and enter RUN.
REQ-015 RUN SHALL perform exactly one iteration per edge on edges E1..EWIDTH, then enter FIX on edge EWIDTH.
REQ-016 MUL SHALL use radix-2 Booth recoding on a 2*WIDTH+1-bit accumulator with an arithmetic right shift each step.
REQ-017 DIV SHALL use restoring division on the operand magnitudes, one quotient bit per step.
REQ-018 On edge EWIDTH+1, FIX SHALL apply DIV sign correction, write hi, lo and dz, and enter DONE.
REQ-019 done SHALL be 1 only during the DONE cycle; on edge EWIDTH+2, DONE SHALL return to IDLE.
REQ-020 Latency from the start-sampling edge to done high SHALL be WIDTH+1 edges, independent of operand values.
REQ-021 MUL result SHALL be the full signed 2*WIDTH-bit product: hi = upper half, lo = lower half.
REQ-022 DIV quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign.
REQ-023 DIV with b=0 SHALL set dz=1, lo=all ones and hi=a, with the same latency.
REQ-024 DIV of the most-negative value by -1 SHALL give lo=most-negative value, hi=0, dz=0.
REQ-025 MUL SHALL always set dz=0.
REQ-026 start in RUN, FIX or DONE SHALL be ignored, with no queuing; changes on a, b or op after E0 SHALL have no effect.
REQ-027 hi, lo and dz SHALL hold their values until the next FIX edge.

Reset
REQ-028 clear=0 SHALL immediately force IDLE, busy=0, done=0, dz=0, hi=0, lo=0 and counter=0, including mid-operation.
REQ-029 An operation interrupted by clear SHALL be discarded; the first start after clear returns high SHALL be accepted normally.

Configuration
REQ-030 With macro MULDIV_DIV_EN defined, both MUL and DIV SHALL be implemented as specified above.
REQ-031 Without MULDIV_DIV_EN, the divider datapath SHALL be absent, op SHALL be ignored (every operation is MUL), and dz SHALL be tied to 0.

Verification
REQ-032 WIDTH=32, MUL a=0x12, b=0x14 -> done after 33 edges, lo=0x00000168, hi=0x00000000.
REQ-033 MUL a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MUL 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 DIV 100/7 -> lo=14, hi=2; DIV -100/7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-035 DIV a=0x1234, b=0 -> dz=1, lo=0xFFFFFFFF, hi=0x00001234; a following MUL -> dz=0.
REQ-036 Pulse start while busy -> ignored and a single done; clear low at RUN step 10 -> all outputs 0 immediately; a restart then completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Sequential signed multiply/divide: radix-2 Booth multiply, restoring divide, WIDTH steps per op.
// Define MULDIV_DIV_EN to include the divider; otherwise every operation is a multiply and dz stays 0.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   bsum;

  // The add is sign-extended one bit so a most-negative multiplicand cannot
  // corrupt the sign that the arithmetic shift carries in.
  always_comb begin
    bsum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   bsum = bsum + {m[WIDTH-1], m};
      2'b10:   bsum = bsum - {m[WIDTH-1], m};
      default: bsum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
  end

`ifdef MULDIV_DIV_EN
  logic             op_q, a_neg, b_neg, dz_q;
  logic [WIDTH-1:0] quo, dvs;
  logic [WIDTH:0]   rem, rsh, rdiff;

  always_comb begin
    rsh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rdiff = rsh - {1'b0, dvs};
  end

  assign dz = dz_q;
`else
  logic unused_op;
  assign unused_op = op;
  assign dz        = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      op_q  <= 1'b0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      dz_q  <= 1'b0;
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH);
            m     <= a;
            acc   <= {{WIDTH{1'b0}}, b, 1'b0};
`ifdef MULDIV_DIV_EN
            op_q  <= op;
            a_neg <= a[WIDTH-1];
            b_neg <= b[WIDTH-1];
            quo   <= a[WIDTH-1] ? -a : a;
            dvs   <= b[WIDTH-1] ? -b : b;
            rem   <= '0;
`endif
          end
        end
        RUN: begin
          acc <= {bsum, acc[WIDTH:1]};
`ifdef MULDIV_DIV_EN
          if (!rdiff[WIDTH]) begin
            rem <= rdiff;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rsh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
`endif
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          done  <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (op_q) begin
            if (dvs == '0) begin
              dz_q <= 1'b1;
              lo   <= '1;
              hi   <= m;
            end else begin
              dz_q <= 1'b0;
              lo   <= (a_neg ^ b_neg) ? -quo : quo;
              hi   <= a_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
          end else begin
            dz_q <= 1'b0;
            hi   <= acc[2*WIDTH:WIDTH+1];
            lo   <= acc[WIDTH:1];
          end
`else
          hi <= acc[2*WIDTH:WIDTH+1];
          lo <= acc[WIDTH:1];
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32); divide vectors apply only when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0, clear = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int vecs = 0, errs = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x, y,
                        input logic [W-1:0] ehi, elo, input logic edz);
    int n;
    @(negedge clock); start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;   // operands must already be latched
    chk({tag, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(W + 1));
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    chk({tag, " dz"}, 64'(dz), 64'(edz));
    @(posedge clock); #1;
    chk({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] lo_seen;

    #12;
    chk("reset outs", {busy, done, dz, hi[28:0], lo[31:0]} , 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    @(negedge clock); clear = 1'b1;

    run_op("mul 12x14", 1'b0, 32'h12, 32'h14, 32'h0, 32'h168, 1'b0);
    run_op("mul -3x5", 1'b0, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("mul minxmin", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run_op("mul 7x-1", 1'b0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
    run_op("mul big", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);

    repeat (3) @(posedge clock);
    #1 chk("hold lo", 64'(lo), 64'h00000001);

`ifdef MULDIV_DIV_EN
    run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div -100/7", 1'b1, -32'sd100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
    run_op("div 100/-7", 1'b1, 32'd100, -32'sd7, 32'd2, 32'hFFFFFFF2, 1'b0);
    run_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("div by 0", 1'b1, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    run_op("mul after dz", 1'b0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
`else
    run_op("op1 is mul", 1'b1, 32'd100, 32'd7, 32'h0, 32'd700, 1'b0);
    run_op("op1 zero b", 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0);
`endif

    // start pulsed mid-operation must be dropped
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clock); start = 1'b0;
    dones = 0; lo_seen = '0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (done) begin dones++; lo_seen = lo; end
    end
    chk("busy start dones", 64'(dones), 64'd1);
    chk("busy start lo", 64'(lo_seen), 64'd12);

    // clear in the middle of RUN
    @(negedge clock); start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    chk("clear flags", {61'd0, busy, done, dz}, 64'd0);
    chk("clear hi", 64'(hi), 64'd0);
    chk("clear lo", 64'(lo), 64'd0);
    @(negedge clock); clear = 1'b1;
    run_op("restart", 1'b0, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
